axum_bus_arb: RTL and testbench

AXUM_BUS_ARB -- requirements
Module: axum_bus_arb

---
 rtl/axum_bus_arb.sv | 172 +++++++++++++++++
 tb/tb_axum_bus_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axum_bus_arb.sv
// axum_bus_arb: round-robin arbiter that funnels NrHosts request/response
// ports onto one shared downstream bus, one transaction outstanding at a time.
//
// Handshake: a host holds host_req_i with stable address/we/be/wdata until it
// sees host_gnt_o for one cycle; the transfer happens in that cycle. The device
// accepts dev_req_o in the cycle it raises dev_gnt_i and later answers with a
// single dev_rvalid_i cycle, which is forwarded to the owning host as a single
// host_rvalid_o cycle. A missing answer is converted into an error response.
module axum_bus_arb #(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NrHosts-1:0]               host_req_i,
    output logic [NrHosts-1:0]               host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]               host_we_i,
    input  logic [NrHosts*4-1:0]             host_be_i,
    input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]               host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]     host_rdata_o,
    output logic [NrHosts-1:0]               host_err_o,
    output logic                             dev_req_o,
    output logic                             dev_we_o,
    output logic [AddressWidth-1:0]          dev_addr_o,
    output logic [3:0]                       dev_be_o,
    output logic [DataWidth-1:0]             dev_wdata_o,
    input  logic                             dev_gnt_i,
    input  logic                             dev_rvalid_i,
    input  logic                             dev_err_i,
    input  logic [DataWidth-1:0]             dev_rdata_i,
    output logic                             busy_o,
    output logic                             timeout_o,
    output logic [1:0]                       state_o
);

    localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e          state;
    logic [IdxW-1:0] owner;
    logic [IdxW-1:0] prio;
    logic [IdxW-1:0] prio_next;
    logic [IdxW-1:0] winner;
    logic [7:0]      cnt;
    logic            busy_q;
    logic            owner_req;
    logic            timeout_hit;

    assign owner_req   = host_req_i[owner];
    assign timeout_hit = (state == RSP) && !dev_rvalid_i &&
                         (cnt == 8'(TimeoutCycles - 1));
    assign prio_next   = (owner == IdxW'(NrHosts - 1)) ? '0 : owner + 1'b1;

    // Round-robin search: first requester at or above prio, wrapping around.
    always_comb begin : rr_search
        int  idx;
        logic found;
        winner = prio;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = int'(prio) + i;
            if (idx >= NrHosts) begin
                idx = idx - NrHosts;
            end
            if (!found && host_req_i[idx]) begin
                winner = idx[IdxW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Arbitration FSM: owner/prio/timeout counter and the busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            owner  <= '0;
            prio   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|host_req_i) begin
                        owner  <= winner;
                        state  <= REQ;
                        busy_q <= 1'b1;
                    end
                end
                REQ: begin
                    // A withdrawn request abandons the slot without moving prio.
                    if (!owner_req) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (dev_gnt_i) begin
                        state <= RSP;
                        prio  <= prio_next;
                        cnt   <= '0;
                    end
                end
                RSP: begin
                    if (dev_rvalid_i || timeout_hit) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Downstream request mux: owner's fields in REQ, all-zero otherwise.
    always_comb begin
        dev_req_o   = 1'b0;
        dev_we_o    = 1'b0;
        dev_addr_o  = '0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (state == REQ) begin
            dev_req_o   = owner_req;
            dev_we_o    = host_we_i[owner];
            dev_addr_o  = host_addr_i[owner*AddressWidth +: AddressWidth];
            dev_be_o    = host_be_i[owner*4 +: 4];
            dev_wdata_o = host_wdata_i[owner*DataWidth +: DataWidth];
        end
    end

    // Grant passthrough to the owner only while its request is on the bus.
    always_comb begin
        host_gnt_o = '0;
        if (state == REQ) begin
            host_gnt_o[owner] = dev_gnt_i & owner_req;
        end
    end

    // Response routing: real response beats a same-cycle timeout.
    always_comb begin
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        if (state == RSP) begin
            if (dev_rvalid_i) begin
                host_rvalid_o[owner]                        = 1'b1;
                host_rdata_o[owner*DataWidth +: DataWidth]  = dev_rdata_i;
                host_err_o[owner]                           = dev_err_i;
            end else if (timeout_hit) begin
                host_rvalid_o[owner] = 1'b1;
                host_err_o[owner]    = 1'b1;
            end
        end
    end

    assign busy_o    = busy_q;
    assign timeout_o = timeout_hit;
    assign state_o   = state;

endmodule

// File: tb/tb_axum_bus_arb.sv
// tb_axum_bus_arb: directed scenarios for the two-host arbiter; expected
// grants and host responses are queued when stimulus is issued and a
// negedge monitor pops and compares whenever the DUT shows one.
module tb_axum_bus_arb;

    localparam int NH  = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int RW  = NH + NH + NH*DW;

    logic              clk_i;
    logic              rst_ni;
    logic [NH-1:0]     host_req_i;
    logic [NH-1:0]     host_gnt_o;
    logic [NH*AW-1:0]  host_addr_i;
    logic [NH-1:0]     host_we_i;
    logic [NH*4-1:0]   host_be_i;
    logic [NH*DW-1:0]  host_wdata_i;
    logic [NH-1:0]     host_rvalid_o;
    logic [NH*DW-1:0]  host_rdata_o;
    logic [NH-1:0]     host_err_o;
    logic              dev_req_o;
    logic              dev_we_o;
    logic [AW-1:0]     dev_addr_o;
    logic [3:0]        dev_be_o;
    logic [DW-1:0]     dev_wdata_o;
    logic              dev_gnt_i;
    logic              dev_rvalid_i;
    logic              dev_err_i;
    logic [DW-1:0]     dev_rdata_i;
    logic              busy_o;
    logic              timeout_o;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;

    logic [NH-1:0] gnt_q[$];
    logic [RW-1:0] exp_q[$];
    logic [NH-1:0] mon_g;
    logic [RW-1:0] mon_r;
    logic [RW-1:0] mon_a;

    axum_bus_arb #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_addr_o(dev_addr_o),
        .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
        .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
        .dev_err_i(dev_err_i), .dev_rdata_i(dev_rdata_i),
        .busy_o(busy_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [RW-1:0] mk_rsp(input int h, input logic e,
                                              input logic [DW-1:0] d);
        logic [NH-1:0]    rv;
        logic [NH-1:0]    er;
        logic [NH*DW-1:0] rd;
        rv = '0;
        er = '0;
        rd = '0;
        rv[h] = 1'b1;
        er[h] = e;
        rd[h*DW +: DW] = d;
        return {rv, er, rd};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        host_req_i   = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = '0;
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    // Scoreboard monitor: grants and responses are compared against queues.
    always @(negedge clk_i) begin
        if (timeout_o) to_cnt++;
        if (host_gnt_o != '0) begin
            checks++;
            if (gnt_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected act=%b exp=none", host_gnt_o);
            end else begin
                mon_g = gnt_q.pop_front();
                if (mon_g !== host_gnt_o) begin
                    errors++;
                    $display("FAIL grant_order act=%b exp=%b", host_gnt_o, mon_g);
                end
            end
        end
        mon_a = {host_rvalid_o, host_err_o, host_rdata_o};
        if (host_rvalid_o != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected act=%0h exp=none", mon_a);
            end else begin
                mon_r = exp_q.pop_front();
                if (mon_r !== mon_a) begin
                    errors++;
                    $display("FAIL rsp_data act=%0h exp=%0h", mon_a, mon_r);
                end
            end
        end else if ((host_err_o != '0) || (host_rdata_o != '0)) begin
            checks++;
            errors++;
            $display("FAIL rsp_idle_nonzero act=%0h exp=0", mon_a);
        end
    end

    initial begin
        rst_ni       = 1'b0;
        host_req_i   = '0;
        host_addr_i  = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_wdata_i = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = '0;

        // Reset state
        neg();
        chk("rst_busy", busy_o, 0);
        chk("rst_gnt", host_gnt_o, 0);
        chk("rst_devreq", dev_req_o, 0);
        chk("rst_devaddr", dev_addr_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_state", state_o, 0);
        cyc();
        rst_ni = 1'b1;

        // Single read by host0, minimum latency
        host_addr_i[31:0]  = 32'h0010_0004;
        host_be_i[3:0]     = 4'hF;
        host_wdata_i[31:0] = 32'h1111_1111;
        host_req_i = 2'b01;
        dev_gnt_i  = 1'b1;
        gnt_q.push_back(2'b01);
        exp_q.push_back(mk_rsp(0, 1'b0, 32'hDEAD_BEEF));
        neg();
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_gnt", host_gnt_o, 0);
        cyc();
        neg();
        chk("t1_gnt", host_gnt_o, 2'b01);
        chk("t1_devreq", dev_req_o, 1);
        chk("t1_devaddr", dev_addr_o, 32'h0010_0004);
        chk("t1_devwe", dev_we_o, 0);
        chk("t1_devbe", dev_be_o, 4'hF);
        chk("t1_devwdata", dev_wdata_o, 32'h1111_1111);
        chk("t1_busy", busy_o, 1);
        cyc();
        host_req_i   = 2'b00;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hDEAD_BEEF;
        neg();
        chk("t1_rvalid", host_rvalid_o, 2'b01);
        chk("t1_rdata", host_rdata_o[31:0], 32'hDEAD_BEEF);
        chk("t1_err", host_err_o, 0);
        chk("t1_rsp_devreq", dev_req_o, 0);
        chk("t1_rsp_devaddr", dev_addr_o, 0);
        cyc();
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        neg();
        chk("t1_done_busy", busy_o, 0);

        // Both hosts requesting continuously: grants alternate 0,1,0,1
        do_reset();
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b1;
        host_req_i   = 2'b11;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        exp_q.push_back(mk_rsp(0, 1'b0, 32'h1000_0002));
        exp_q.push_back(mk_rsp(1, 1'b0, 32'h1000_0005));
        exp_q.push_back(mk_rsp(0, 1'b0, 32'h1000_0008));
        exp_q.push_back(mk_rsp(1, 1'b0, 32'h1000_000B));
        for (int k = 0; k < 12; k++) begin
            dev_rdata_i = 32'h1000_0000 + 32'(k);
            if (k == 11) host_req_i = 2'b00;
            neg();
            chk("t2_busy", busy_o, ((k % 3) != 0) ? 1 : 0);
            cyc();
        end
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        neg();
        chk("t2_idle", busy_o, 0);

        // Device stalls grant for 5 cycles with host1 as owner
        do_reset();
        host_addr_i[63:32]  = 32'h2000_0040;
        host_we_i           = 2'b10;
        host_be_i[7:4]      = 4'h3;
        host_wdata_i[63:32] = 32'hCAFE_F00D;
        host_req_i = 2'b10;
        cyc();
        for (int s = 1; s <= 5; s++) begin
            if (s == 2) host_req_i = 2'b11;
            neg();
            chk("t3_stall_addr", dev_addr_o, 32'h2000_0040);
            chk("t3_stall_wdata", dev_wdata_o, 32'hCAFE_F00D);
            chk("t3_stall_we", dev_we_o, 1);
            chk("t3_stall_gnt", host_gnt_o, 0);
            chk("t3_stall_state", state_o, 1);
            cyc();
        end
        dev_gnt_i = 1'b1;
        gnt_q.push_back(2'b10);
        neg();
        chk("t3_gnt", host_gnt_o, 2'b10);
        chk("t3_be", dev_be_o, 4'h3);
        cyc();
        host_req_i   = 2'b01;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        dev_rdata_i  = 32'h0BAD_F00D;
        exp_q.push_back(mk_rsp(1, 1'b1, 32'h0BAD_F00D));
        cyc();

        // Host0 granted next, device never answers: timeout on 16th RSP cycle
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = 32'hFFFF_FFFF;
        dev_gnt_i    = 1'b1;
        gnt_q.push_back(2'b01);
        cyc();
        cyc();
        dev_gnt_i  = 1'b0;
        host_req_i = 2'b00;
        to_cnt     = 0;
        for (int c = 0; c < 15; c++) begin
            neg();
            chk("t4_no_timeout", timeout_o, 0);
            cyc();
        end
        exp_q.push_back(mk_rsp(0, 1'b1, 32'h0));
        neg();
        chk("t4_timeout", timeout_o, 1);
        chk("t4_to_rdata", host_rdata_o, 0);
        cyc();
        neg();
        chk("t4_after_timeout", timeout_o, 0);
        chk("t4_after_busy", busy_o, 0);
        cyc();
        dev_rvalid_i = 1'b1;
        neg();
        chk("t4_stray_rvalid", host_rvalid_o, 0);
        cyc();
        dev_rvalid_i = 1'b0;
        chk("t4_pulse_count", to_cnt, 1);

        // Real response on the timeout cycle wins; prio points at host1
        host_req_i = 2'b10;
        dev_gnt_i  = 1'b1;
        gnt_q.push_back(2'b10);
        cyc();
        cyc();
        host_req_i = 2'b00;
        dev_gnt_i  = 1'b0;
        repeat (15) cyc();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h1234_5678;
        exp_q.push_back(mk_rsp(1, 1'b0, 32'h1234_5678));
        neg();
        chk("t5_race_timeout", timeout_o, 0);
        chk("t5_race_rvalid", host_rvalid_o, 2'b10);
        cyc();
        dev_rvalid_i = 1'b0;
        chk("t5_pulse_count", to_cnt, 1);

        // Reset during host1's RSP aborts it; first grant after goes to host0
        host_req_i = 2'b10;
        dev_gnt_i  = 1'b1;
        gnt_q.push_back(2'b10);
        cyc();
        cyc();
        rst_ni       = 1'b0;
        host_req_i   = 2'b00;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h7777_7777;
        neg();
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_rvalid", host_rvalid_o, 0);
        chk("t6_rst_state", state_o, 0);
        cyc();
        host_req_i   = 2'b11;
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b0;
        cyc();
        rst_ni = 1'b1;
        gnt_q.push_back(2'b01);
        cyc();
        neg();
        chk("t6_first_gnt", host_gnt_o, 2'b01);
        cyc();
        host_req_i   = 2'b10;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hA5A5_A5A5;
        exp_q.push_back(mk_rsp(0, 1'b0, 32'hA5A5_A5A5));
        cyc();

        // Host1 withdraws while stalled in REQ: no grant, prio stays at host1
        dev_rvalid_i = 1'b0;
        cyc();
        host_req_i = 2'b00;
        neg();
        chk("t7_withdraw_gnt", host_gnt_o, 0);
        cyc();
        neg();
        chk("t7_withdraw_idle", busy_o, 0);
        host_req_i = 2'b11;
        dev_gnt_i  = 1'b1;
        gnt_q.push_back(2'b10);
        cyc();
        neg();
        chk("t7_prio_kept", host_gnt_o, 2'b10);
        cyc();
        host_req_i   = 2'b00;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0F0F_0F0F;
        exp_q.push_back(mk_rsp(1, 1'b0, 32'h0F0F_0F0F));
        cyc();
        dev_rvalid_i = 1'b0;
        cyc();
        cyc();

        // Everything promised must have been seen
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
